// File: rtl/reaction_sequencer.sv
// reaction_sequencer: master controller for a two-player reaction-time tester.
//
// It walks an 8-state sequence, published on machine_state for Random and the display:
//   IDLE -> WAIT -> CLR_CNT1 -> START -> STORAGE -> (CLR_CNT2 -> WAIT ...) -> AVERAGE -> COMPARE
// Each round works as follows:
//   - Latch a clamped random pre-light delay.
//   - Flag early presses as fouls.
//   - Light led_go and time each player's first press in ms.
//   - Accumulate ROUNDS results per player.
// After the last round it averages the results and declares the winner.
//
// Ports:
//   clk, rstn (sync, active-high)       clock / reset
//   tick_1ms                            1 ms strobe, counted only in WAIT and START
//   start_btn                           start pulse, honoured in IDLE and COMPARE
//   btn_a, btn_b                        player press levels
//   rand_num[13:0]                      random delay source
//   machine_state[2:0]                  current state
//   led_go                              react-now light
//   cnt_ms[13:0]                        live reaction counter
//   time_a/b[13:0], foul_a/b            last-round result per player
//   round_idx[2:0]                      completed rounds
//   avg_a/b[13:0], result_valid, winner, tie   end-of-game result (winner: 1 = A)
module reaction_sequencer #(
  parameter int ROUNDS      = 4,
  parameter int MIN_WAIT_MS = 1000,
  parameter int MAX_WAIT_MS = 5000,
  parameter int TIMEOUT_MS  = 2000,
  parameter int MAX_TIME    = 9999
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        tick_1ms,
  input  logic        start_btn,
  input  logic        btn_a,
  input  logic        btn_b,
  input  logic [13:0] rand_num,
  output logic [2:0]  machine_state,
  output logic        led_go,
  output logic [13:0] cnt_ms,
  output logic [13:0] time_a,
  output logic [13:0] time_b,
  output logic        foul_a,
  output logic        foul_b,
  output logic [2:0]  round_idx,
  output logic [13:0] avg_a,
  output logic [13:0] avg_b,
  output logic        result_valid,
  output logic        winner,
  output logic        tie
);
  localparam int          LG       = $clog2(ROUNDS);
  localparam int          SW       = 14 + LG;
  localparam logic [13:0] MIN_W    = 14'(MIN_WAIT_MS);
  localparam logic [13:0] MAX_W    = 14'(MAX_WAIT_MS);
  localparam logic [13:0] TOUT     = 14'(TIMEOUT_MS);
  localparam logic [13:0] MAX_T    = 14'(MAX_TIME);
  localparam logic [3:0]  ROUNDS_N = 4'(ROUNDS);

  typedef enum logic [2:0] {
    IDLE = 3'd0, WAIT = 3'd1, CLR_CNT1 = 3'd2, START = 3'd3,
    STORAGE = 3'd4, CLR_CNT2 = 3'd5, AVERAGE = 3'd6, COMPARE = 3'd7
  } state_t;

  state_t        state;
  logic [13:0]   target, dcnt;
  logic          cap_a, cap_b;
  logic [SW-1:0] sum_a, sum_b;

  logic [13:0] rand_clamped, dcnt_inc, cnt_inc, avg_a_n, avg_b_n;
  logic        press_a, press_b, done_a, done_b, leave_start;
  logic [3:0]  round_nxt;

  always_comb begin
    rand_clamped = rand_num;
    if (rand_num < MIN_W)      rand_clamped = MIN_W;
    else if (rand_num > MAX_W) rand_clamped = MAX_W;
  end

  assign dcnt_inc = dcnt + 14'd1;
  assign cnt_inc  = (cnt_ms >= MAX_T) ? MAX_T : cnt_ms + 14'd1;

  // A press counts only once per round and never for a fouled player.
  assign press_a = btn_a && !cap_a && !foul_a;
  assign press_b = btn_b && !cap_b && !foul_b;
  // A same-cycle press already counts as done, so START exits on the capture edge.
  assign done_a      = cap_a || foul_a || btn_a;
  assign done_b      = cap_b || foul_b || btn_b;
  assign leave_start = (done_a && done_b) || (cnt_ms == TOUT);

  // The count is one bit wider so that ROUNDS = 8 is detected.
  // round_idx itself then wraps to 0.
  assign round_nxt = {1'b0, round_idx} + 4'd1;
  assign avg_a_n   = 14'(sum_a >> LG);
  assign avg_b_n   = 14'(sum_b >> LG);

  assign machine_state = state;

  always_ff @(posedge clk) begin
    if (rstn) begin
      state        <= IDLE;
      target       <= '0;
      dcnt         <= '0;
      cap_a        <= 1'b0;
      cap_b        <= 1'b0;
      sum_a        <= '0;
      sum_b        <= '0;
      led_go       <= 1'b0;
      cnt_ms       <= '0;
      time_a       <= '0;
      time_b       <= '0;
      foul_a       <= 1'b0;
      foul_b       <= 1'b0;
      round_idx    <= '0;
      avg_a        <= '0;
      avg_b        <= '0;
      result_valid <= 1'b0;
      winner       <= 1'b0;
      tie          <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start_btn) begin
          state        <= WAIT;
          sum_a        <= '0;
          sum_b        <= '0;
          round_idx    <= '0;
          avg_a        <= '0;
          avg_b        <= '0;
          result_valid <= 1'b0;
          winner       <= 1'b0;
          tie          <= 1'b0;
          foul_a       <= 1'b0;  // fouls belong to a round, never carried into a new game
          foul_b       <= 1'b0;
          target       <= rand_clamped;
          dcnt         <= '0;
        end
        WAIT: begin
          led_go <= 1'b0;
          if (btn_a) foul_a <= 1'b1;
          if (btn_b) foul_b <= 1'b1;
          if (tick_1ms) begin
            dcnt <= dcnt_inc;
            if (dcnt_inc == target) state <= CLR_CNT1;
          end
        end
        CLR_CNT1: begin
          cnt_ms <= '0;
          cap_a  <= 1'b0;
          cap_b  <= 1'b0;
          led_go <= 1'b1;
          state  <= START;
        end
        START: begin
          if (tick_1ms) cnt_ms <= cnt_inc;
          // Capture the pre-increment count.
          if (press_a) begin time_a <= cnt_ms; cap_a <= 1'b1; end
          if (press_b) begin time_b <= cnt_ms; cap_b <= 1'b1; end
          if (leave_start) begin
            state  <= STORAGE;
            led_go <= 1'b0;
            if (!press_a && !cap_a) time_a <= MAX_T;
            if (!press_b && !cap_b) time_b <= MAX_T;
          end
        end
        STORAGE: begin
          sum_a     <= sum_a + SW'(time_a);
          sum_b     <= sum_b + SW'(time_b);
          round_idx <= round_nxt[2:0];
          state     <= (round_nxt == ROUNDS_N) ? AVERAGE : CLR_CNT2;
        end
        CLR_CNT2: begin
          led_go <= 1'b0;
          cnt_ms <= '0;
          foul_a <= 1'b0;
          foul_b <= 1'b0;
          target <= rand_clamped;
          dcnt   <= '0;
          state  <= WAIT;
        end
        AVERAGE: begin
          // Decide on the truncated averages so the result matches what is displayed.
          avg_a        <= avg_a_n;
          avg_b        <= avg_b_n;
          result_valid <= 1'b1;
          winner       <= (avg_a_n < avg_b_n);
          tie          <= (avg_a_n == avg_b_n);
          state        <= COMPARE;
        end
        COMPARE: if (start_btn) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_reaction_sequencer.sv
// Testbench for reaction_sequencer.
// Games are driven by per-round plans: a rand_num value and each player's press delay
// in ticks, a foul, or no press. A plan-level model predicts the expected results:
// wait length, captured times, fouls, START exit point and averages.
module tb_reaction_sequencer;
  localparam int ROUNDS = 4;
  localparam int MINW   = 1000;
  localparam int MAXW   = 5000;
  localparam int TOUT   = 2000;
  localparam int MAXT   = 9999;
  localparam int NONE   = -1;
  localparam int FOUL   = -2;

  logic        clk = 1'b0;
  logic        rstn, tick_1ms, start_btn, btn_a, btn_b;
  logic [13:0] rand_num;
  logic [2:0]  machine_state, round_idx;
  logic        led_go, foul_a, foul_b, result_valid, winner, tie;
  logic [13:0] cnt_ms, time_a, time_b, avg_a, avg_b;

  reaction_sequencer dut (
    .clk(clk), .rstn(rstn), .tick_1ms(tick_1ms), .start_btn(start_btn),
    .btn_a(btn_a), .btn_b(btn_b), .rand_num(rand_num),
    .machine_state(machine_state), .led_go(led_go), .cnt_ms(cnt_ms),
    .time_a(time_a), .time_b(time_b), .foul_a(foul_a), .foul_b(foul_b),
    .round_idx(round_idx), .avg_a(avg_a), .avg_b(avg_b),
    .result_valid(result_valid), .winner(winner), .tie(tie)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit lost   = 1'b0;
  int plan_rn[ROUNDS];
  int plan_a[ROUNDS];
  int plan_b[ROUNDS];
  int sum_a_m, sum_b_m;

  function automatic int clampw(input int v);
    return (v < MINW) ? MINW : (v > MAXW) ? MAXW : v;
  endfunction

  function automatic int imax(input int x, input int y);
    return (x > y) ? x : y;
  endfunction

  initial begin
    #3000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    rstn = 1'b1; start_btn = 1'b0; btn_a = 1'b0; btn_b = 1'b0; tick_1ms = 1'b0;
    rand_num = 14'd0;
    repeat (3) begin
      tick_1ms = 1'($urandom); btn_a = 1'($urandom); btn_b = 1'($urandom);
      @(negedge clk);
    end
    checks++;
    if (machine_state !== 3'd0 || led_go !== 1'b0 || cnt_ms !== 14'd0 || round_idx !== 3'd0) begin
      errors++;
      $display("FAIL reset_ctrl got state=%0d led=%0d cnt=%0d idx=%0d exp all 0",
               machine_state, led_go, cnt_ms, round_idx);
    end
    checks++;
    if ({time_a, time_b, foul_a, foul_b, avg_a, avg_b, result_valid, winner, tie} !== 61'd0) begin
      errors++;
      $display("FAIL reset_results got ta=%0d tb=%0d fa=%0d fb=%0d aa=%0d ab=%0d rv=%0d w=%0d t=%0d exp all 0",
               time_a, time_b, foul_a, foul_b, avg_a, avg_b, result_valid, winner, tie);
    end
    rstn = 1'b0; btn_a = 1'b0; btn_b = 1'b0;
    repeat (4) begin tick_1ms = 1'($urandom); @(negedge clk); end
    checks++;
    if (machine_state !== 3'd0) begin
      errors++; $display("FAIL idle_hold got state=%0d exp 0", machine_state);
    end
  endtask

  task automatic start_game();
    if (lost) return;
    sum_a_m = 0; sum_b_m = 0;
    btn_a = 1'b0; btn_b = 1'b0;
    repeat (3) begin tick_1ms = 1'($urandom); @(negedge clk); end
    rand_num = 14'(plan_rn[0]); start_btn = 1'b1; tick_1ms = 1'($urandom);
    @(negedge clk);
    start_btn = 1'b0;
    checks++;
    if (machine_state !== 3'd1 || result_valid !== 1'b0 || avg_a !== 14'd0 || avg_b !== 14'd0) begin
      errors++; lost = 1'b1;
      $display("FAIL game_start got state=%0d rv=%0d aa=%0d ab=%0d exp state=1 rv=0 avg=0",
               machine_state, result_valid, avg_a, avg_b);
    end
  endtask

  task automatic run_round(input int r);
    int  wt, k, last_k, guard, ea, eb, ek;
    bit  pa, pb, ga, gb, last;
    if (lost) return;
    last = (r == ROUNDS - 1);
    checks++;
    if (machine_state !== 3'd1 || round_idx !== 3'(r)) begin
      errors++; lost = 1'b1;
      $display("FAIL round_entry r=%0d got state=%0d idx=%0d exp state=1 idx=%0d", r, machine_state, round_idx, r);
      return;
    end
    if (r > 0) begin
      checks++;
      if (foul_a !== 1'b0 || foul_b !== 1'b0 || cnt_ms !== 14'd0 || led_go !== 1'b0) begin
        errors++;
        $display("FAIL clr_cnt2 r=%0d got fa=%0d fb=%0d cnt=%0d led=%0d exp all 0", r, foul_a, foul_b, cnt_ms, led_go);
      end
    end
    // WAIT: scramble rand_num (already latched), inject early presses for foul plans.
    wt = 0; guard = 0;
    while (machine_state == 3'd1 && guard < 12000) begin
      tick_1ms  = ($urandom % 8) != 0;
      rand_num  = 14'($urandom);
      start_btn = ($urandom % 512) == 0;
      btn_a     = (plan_a[r] == FOUL) && wt >= 5 && wt < 15;
      btn_b     = (plan_b[r] == FOUL) && wt >= 8 && wt < 12;
      if (tick_1ms) wt++;
      @(negedge clk); guard++;
    end
    checks++;
    if (machine_state !== 3'd2 || wt != clampw(plan_rn[r])) begin
      errors++;
      $display("FAIL wait_len r=%0d got state=%0d ticks=%0d exp state=2 ticks=%0d", r, machine_state, wt, clampw(plan_rn[r]));
      if (machine_state !== 3'd2) begin lost = 1'b1; return; end
    end
    // CLR_CNT1: present the next round's rand_num, held until its WAIT entry.
    btn_a = 1'b0; btn_b = 1'b0; start_btn = 1'b0; tick_1ms = 1'($urandom);
    if (last) rand_num = 14'($urandom);
    else      rand_num = 14'(plan_rn[r+1]);
    @(negedge clk);
    checks++;
    if (machine_state !== 3'd3 || led_go !== 1'b1 || cnt_ms !== 14'd0) begin
      errors++; lost = 1'b1;
      $display("FAIL start_entry r=%0d got state=%0d led=%0d cnt=%0d exp 3/1/0", r, machine_state, led_go, cnt_ms);
      return;
    end
    // START: k counts ticks applied since light-on; press exactly when k hits the plan.
    k = 0; last_k = 0; guard = 0; pa = 1'b0; pb = 1'b0;
    while (machine_state == 3'd3 && guard < 4000) begin
      last_k    = k;
      ga        = plan_a[r] >= 0 && !pa && k == plan_a[r];
      gb        = plan_b[r] >= 0 && !pb && k == plan_b[r];
      tick_1ms  = (ga && gb) ? 1'b1 : (($urandom % 8) != 0);
      btn_a     = (plan_a[r] == FOUL || pa) ? 1'($urandom) : ga;
      btn_b     = (plan_b[r] == FOUL || pb) ? 1'($urandom) : gb;
      pa        = pa | ga;
      pb        = pb | gb;
      start_btn = ($urandom % 512) == 0;
      if (tick_1ms) k++;
      @(negedge clk); guard++;
    end
    btn_a = 1'b0; btn_b = 1'b0; start_btn = 1'b0;
    ea = (plan_a[r] >= 0) ? plan_a[r] : MAXT;
    eb = (plan_b[r] >= 0) ? plan_b[r] : MAXT;
    ek = (plan_a[r] != NONE && plan_b[r] != NONE) ? imax(imax(plan_a[r], 0), imax(plan_b[r], 0)) : TOUT;
    sum_a_m += ea; sum_b_m += eb;
    checks++;
    if (machine_state !== 3'd4 || last_k != ek || round_idx !== 3'(r)) begin
      errors++;
      $display("FAIL start_exit r=%0d got state=%0d exit_ms=%0d idx=%0d exp state=4 exit_ms=%0d idx=%0d",
               r, machine_state, last_k, round_idx, ek, r);
      if (machine_state !== 3'd4) begin lost = 1'b1; return; end
    end
    checks++;
    if (time_a !== 14'(ea) || time_b !== 14'(eb)) begin
      errors++;
      $display("FAIL times r=%0d got a=%0d b=%0d exp a=%0d b=%0d", r, time_a, time_b, ea, eb);
    end
    checks++;
    if (foul_a !== (plan_a[r] == FOUL) || foul_b !== (plan_b[r] == FOUL)) begin
      errors++;
      $display("FAIL fouls r=%0d got a=%0d b=%0d exp a=%0d b=%0d", r, foul_a, foul_b, plan_a[r] == FOUL, plan_b[r] == FOUL);
    end
    tick_1ms = 1'($urandom);
    @(negedge clk);
    checks++;
    if (round_idx !== 3'(r + 1) || machine_state !== (last ? 3'd6 : 3'd5)) begin
      errors++; lost = 1'b1;
      $display("FAIL storage r=%0d got idx=%0d state=%0d exp idx=%0d state=%0d", r, round_idx, machine_state, r + 1, last ? 6 : 5);
      return;
    end
    tick_1ms = 1'($urandom);
    @(negedge clk);
    checks++;
    if (machine_state !== (last ? 3'd7 : 3'd1)) begin
      errors++; lost = 1'b1;
      $display("FAIL round_tail r=%0d got state=%0d exp %0d", r, machine_state, last ? 7 : 1);
    end
  endtask

  task automatic finish_game();
    int aa, ab;
    if (lost) return;
    aa = sum_a_m / ROUNDS;
    ab = sum_b_m / ROUNDS;
    checks++;
    if (avg_a !== 14'(aa) || avg_b !== 14'(ab)) begin
      errors++; $display("FAIL averages got a=%0d b=%0d exp a=%0d b=%0d", avg_a, avg_b, aa, ab);
    end
    checks++;
    if (result_valid !== 1'b1 || winner !== (aa < ab) || tie !== (aa == ab)) begin
      errors++;
      $display("FAIL verdict got rv=%0d w=%0d t=%0d exp rv=1 w=%0d t=%0d", result_valid, winner, tie, aa < ab, aa == ab);
    end
    repeat (5) begin
      tick_1ms = 1'($urandom); btn_a = 1'($urandom); btn_b = 1'($urandom);
      @(negedge clk);
    end
    btn_a = 1'b0; btn_b = 1'b0;
    checks++;
    if (machine_state !== 3'd7 || result_valid !== 1'b1) begin
      errors++; $display("FAIL compare_hold got state=%0d rv=%0d exp 7/1", machine_state, result_valid);
    end
    start_btn = 1'b1;
    @(negedge clk);
    start_btn = 1'b0;
    checks++;
    if (machine_state !== 3'd0) begin
      errors++; lost = 1'b1; $display("FAIL compare_exit got state=%0d exp 0", machine_state);
    end
  endtask

  task automatic play_game();
    start_game();
    for (int r = 0; r < ROUNDS; r++) run_round(r);
    finish_game();
  endtask

  task automatic set_random_plan();
    int x;
    for (int r = 0; r < ROUNDS; r++) begin
      plan_rn[r] = $urandom_range(0, 1300);
      x = $urandom % 8;
      plan_a[r] = (x == 0) ? NONE : (x == 1) ? FOUL : $urandom_range(0, 1999);
      x = $urandom % 8;
      plan_b[r] = (x == 0) ? NONE : (x == 1) ? FOUL : $urandom_range(0, 1999);
    end
    if (plan_a[ROUNDS-1] == FOUL) plan_a[ROUNDS-1] = $urandom_range(0, 1999);
    if (plan_b[ROUNDS-1] == FOUL) plan_b[ROUNDS-1] = $urandom_range(0, 1999);
  endtask

  task automatic test_basic_game();
    for (int r = 0; r < ROUNDS; r++) begin plan_rn[r] = 1500; plan_a[r] = 200; plan_b[r] = 300; end
    play_game();
  endtask

  task automatic test_clamp_foul_timeout();
    plan_rn = '{200, 9000, 1000, 1200};
    plan_a  = '{FOUL, NONE, 180, 700};
    plan_b  = '{250, NONE, 180, 900};
    play_game();
  endtask

  task automatic test_tie();
    for (int r = 0; r < ROUNDS; r++) begin plan_rn[r] = $urandom_range(0, 1100); plan_a[r] = 180; plan_b[r] = 180; end
    play_game();
  endtask

  task automatic test_reset_mid();
    int guard;
    set_random_plan();
    start_game();
    run_round(0);
    if (lost) return;
    guard = 0;
    while (machine_state != 3'd3 && guard < 12000) begin
      tick_1ms = ($urandom % 8) != 0; btn_a = 1'b0; btn_b = 1'b0;
      @(negedge clk); guard++;
    end
    repeat (20) begin
      tick_1ms = 1'b1; btn_a = 1'($urandom); btn_b = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (led_go !== 1'b1) begin
      errors++; $display("FAIL mid_led got led=%0d exp 1", led_go);
    end
    rstn = 1'b1; tick_1ms = 1'b1; btn_a = 1'b1; btn_b = 1'b1;
    @(negedge clk);
    rstn = 1'b0; btn_a = 1'b0; btn_b = 1'b0;
    checks++;
    if (machine_state !== 3'd0 || led_go !== 1'b0 || cnt_ms !== 14'd0 || round_idx !== 3'd0) begin
      errors++;
      $display("FAIL mid_reset got state=%0d led=%0d cnt=%0d idx=%0d exp all 0", machine_state, led_go, cnt_ms, round_idx);
    end
    checks++;
    if ({time_a, time_b, foul_a, foul_b, avg_a, avg_b, result_valid} !== 59'd0) begin
      errors++;
      $display("FAIL mid_reset_results got ta=%0d tb=%0d fa=%0d fb=%0d rv=%0d exp all 0", time_a, time_b, foul_a, foul_b, result_valid);
    end
  endtask

  initial begin
    rstn = 1'b1; tick_1ms = 1'b0; start_btn = 1'b0; btn_a = 1'b0; btn_b = 1'b0; rand_num = 14'd0;
    @(negedge clk);
    test_reset();
    test_basic_game();
    test_clamp_foul_timeout();
    test_tie();
    test_reset_mid();
    // Averages right after a mid-game reset also prove the sums were cleared.
    for (int g = 0; g < 2; g++) begin set_random_plan(); play_game(); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
